// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader and the fetch controller.
package instr_loader_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_loader_addr_cnt.sv
// Word counter plus write address; the address holds on the final word so it never wraps.
module loader_addr_cnt
    import instr_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic [ADDR_W:0]   len_eff,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0] cnt;

    assign last = (cnt + CNT_W'(1)) == len_eff;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            addr <= '0;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (!last) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams instruction words from a valid/ready source into the instruction RAM
// while holding the fetch controller in reset.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              InstrRAMenable,
    output logic              InstrRAMwrite_en,
    output logic              InstrRAMread_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              hold_fetch
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t           state, next;
    logic [CNT_W-1:0] len_sel, len_eff;
    logic             clear, step, capture, last;

    // Lengths beyond the RAM depth are clamped so the load stops at the top address.
    assign len_sel = (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
    assign clear   = (state == IDLE) && start;
    assign step    = (state == WRITE) && !abort;
    assign capture = (state == LOAD) && in_valid && !abort;

    loader_addr_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .step    (step),
        .len_eff (len_eff),
        .addr    (ram_addr),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len_eff   <= '0;
            ram_wdata <= '0;
        end else begin
            state <= next;
            if (clear) begin
                len_eff <= len_sel;
            end
            if (capture) begin
                ram_wdata <= in_data;
            end
        end
    end

    always_comb begin
        next             = state;
        in_ready         = 1'b0;
        InstrRAMenable   = 1'b0;
        InstrRAMwrite_en = 1'b0;
        InstrRAMread_en  = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        hold_fetch       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next = (len_sel != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                in_ready   = 1'b1;
                busy       = 1'b1;
                hold_fetch = 1'b1;
                if (abort) begin
                    next = IDLE;
                end else if (in_valid) begin
                    next = WRITE;
                end
            end
            WRITE: begin
                InstrRAMenable   = 1'b1;
                InstrRAMwrite_en = 1'b1;
                busy             = 1'b1;
                hold_fetch       = 1'b1;
                if (abort) begin
                    next = IDLE;
                end else begin
                    next = last ? DONE : LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench: the source driver queues expected writes, a monitor checks each RAM strobe.
module tb_instr_loader;

    logic       clk = 1'b0;
    logic       reset, start, abort, in_valid;
    logic [5:0] len;
    logic [7:0] in_data;
    logic       in_ready, ram_en, ram_we, ram_re, busy, done, hold_fetch;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         load_cyc = 0;
    bit         mon_en   = 1'b0;
    logic [12:0] exp_q[$];

    instr_loader #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .len              (len),
        .abort            (abort),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .InstrRAMenable   (ram_en),
        .InstrRAMwrite_en (ram_we),
        .InstrRAMread_en  (ram_re),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .busy             (busy),
        .done             (done),
        .hold_fetch       (hold_fetch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        logic [12:0] e;
        if (mon_en) begin
            chk("read_en_zero", 32'(ram_re), 32'd0);
            chk("hold_eq_busy", 32'(hold_fetch), 32'(busy));
            chk("en_eq_we", 32'(ram_en), 32'(ram_we));
            if (ram_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: addr %0d data 0x%0h with nothing expected", ram_addr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(e[12:8]));
                    chk("wr_data", 32'(ram_wdata), 32'(e[7:0]));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_re"}, 32'(ram_re), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(hold_fetch), 32'd0);
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic start_load(input logic [5:0] n);
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start    = 1'b0;
        load_cyc = cyc;
    endtask

    task automatic send_word(input logic [4:0] a, input logic [7:0] d, input int gap);
        bit ok = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
            if (gap >= 2) chk("in_ready_hold", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) exp_q.push_back({a, d});
        else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word addr %0d never accepted", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int at_cyc, output logic [4:0] at_addr);
        bit ok = 1'b0;
        at_cyc  = -1;
        at_addr = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                ok      = 1'b1;
                at_cyc  = cyc;
                at_addr = ram_addr;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: no done pulse seen");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int         dc, base;
        logic [4:0] da;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; len = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;

        // Three words, valid held high: done six cycles after LOAD entry.
        base = done_cnt;
        start_load(6'd3);
        send_word(5'd0, 8'hA1, 0);
        send_word(5'd1, 8'hB2, 0);
        send_word(5'd2, 8'hC3, 0);
        wait_done(dc, da);
        in_valid = 1'b0;
        chk("len3_done_latency", 32'(dc - load_cyc), 32'd6);
        repeat (3) @(posedge clk); #1;
        chk("len3_done_once", 32'(done_cnt - base), 32'd1);
        chk("len3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero length: straight to DONE, no write, never busy.
        base = done_cnt;
        start_load(6'd0);
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("len0_done_drop", 32'(done), 32'd0);
        chk("len0_busy2", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("len0_done_once", 32'(done_cnt - base), 32'd1);

        // Oversized length clamps to 32 words, address stops at 31.
        base = done_cnt;
        start_load(6'd40);
        for (int i = 0; i < 32; i++) send_word(5'(i), 8'(i * 9 + 16), 0);
        wait_done(dc, da);
        in_valid = 1'b0;
        chk("len40_addr_at_done", 32'(da), 32'd31);
        chk("len40_done_latency", 32'(dc - load_cyc), 32'd64);
        repeat (3) @(posedge clk); #1;
        chk("len40_done_once", 32'(done_cnt - base), 32'd1);
        chk("len40_queue_empty", 32'(exp_q.size()), 32'd0);

        // Source stall before word 2.
        base = done_cnt;
        start_load(6'd4);
        send_word(5'd0, 8'h11, 0);
        send_word(5'd1, 8'h22, 0);
        send_word(5'd2, 8'h33, 5);
        send_word(5'd3, 8'h44, 0);
        wait_done(dc, da);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("stall_done_once", 32'(done_cnt - base), 32'd1);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort during the write of word 1.
        base = done_cnt;
        start_load(6'd4);
        send_word(5'd0, 8'h5A, 0);
        send_word(5'd1, 8'h6B, 0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_we", 32'(ram_we), 32'd1);
        chk("abort_addr", 32'(ram_addr), 32'd1);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hold", 32'(hold_fetch), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk); #1;
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in LOAD after two writes, then a one-word load.
        start_load(6'd4);
        send_word(5'd0, 8'h77, 0);
        send_word(5'd1, 8'h88, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_in_load", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        base = done_cnt;
        start_load(6'd1);
        send_word(5'd0, 8'h9C, 0);
        wait_done(dc, da);
        in_valid = 1'b0;
        chk("len1_done_latency", 32'(dc - load_cyc), 32'd2);
        repeat (3) @(posedge clk); #1;
        chk("len1_done_once", 32'(done_cnt - base), 32'd1);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
